wb_port_arbiter: RTL

//  Shares the register-file write ports among the execution-unit result producers
//  (ALU0, ALU1, MEM). Each producer has a 1-entry holding buffer with a valid/ready handshake.

---
 rtl/wb_port_arbiter_pkg.sv | 14 +
 rtl/wb_port_arbiter_if.sv | 14 +
 rtl/wb_port_arbiter_src_buf.sv | 56 +++++
 rtl/wb_port_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared sizes, types and pc-order helper for the writeback port arbiter
package wb_port_arbiter_pkg;
    localparam int NSRC       = 3;
    localparam int NWP        = 2;
    localparam int XLEN       = 64;
    localparam int STARVE_LIM = 255;
    localparam int CNT_W      = 8;
    typedef logic [XLEN-1:0]  word_t;
    typedef logic [4:0]       rd_t;
    typedef logic [CNT_W-1:0] cnt_t;
    function automatic logic older(word_t pa, int ia, word_t pb, int ib);
        return pa < pb || (pa == pb && ia < ib);
    endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: producer result handshake and regfile write-port bundle
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;
    logic [NSRC-1:0]  req_valid;
    logic [NSRC-1:0]  req_ready;
    word_t [NSRC-1:0] req_data;
    rd_t [NSRC-1:0]   req_addr;
    word_t [NSRC-1:0] req_pc;
    logic [NWP-1:0]   wp_ena;
    rd_t [NWP-1:0]    wp_addr;
    word_t [NWP-1:0]  wp_data;
    modport master (output req_valid, req_data, req_addr, req_pc, input req_ready, wp_ena, wp_addr, wp_data);
    modport slave (input req_valid, req_data, req_addr, req_pc, output req_ready, wp_ena, wp_addr, wp_data);
endinterface

// File: rtl/wb_port_arbiter_src_buf.sv
// wb_port_arbiter_src_buf: one-entry result holding buffer with handshake, age counter and sticky starve flag
module wb_port_arbiter_src_buf
    import wb_port_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush_i,
    input  logic  valid_i,
    input  word_t data_i,
    input  rd_t   addr_i,
    input  word_t pc_i,
    input  logic  grant_i,
    output logic  ready_o,
    output logic  v_o,
    output word_t data_o,
    output rd_t   addr_o,
    output word_t pc_o,
    output logic  starve_o
);
    logic  v_q, v_d, err_q, err_d, fill;
    word_t data_q, pc_q;
    rd_t   addr_q;
    cnt_t  cnt_q, cnt_d;
    // Draining and refilling in the same cycle keeps the producer at full rate.
    assign ready_o = !flush_i && (!v_q || grant_i);
    assign fill    = valid_i && ready_o;
    always_comb begin
        v_d   = flush_i ? 1'b0 : fill ? 1'b1 : grant_i ? 1'b0 : v_q;
        cnt_d = fill ? '0 : (v_q && !grant_i && cnt_q != cnt_t'(STARVE_LIM)) ? cnt_q + 1'b1 : cnt_q;
        err_d = err_q || cnt_d == cnt_t'(STARVE_LIM);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            pc_q   <= '0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            if (fill) begin
                data_q <= data_i;
                addr_q <= addr_i;
                pc_q   <= pc_i;
            end
        end
    end
    assign v_o      = v_q;
    assign data_o   = data_q;
    assign addr_o   = addr_q;
    assign pc_o     = pc_q;
    assign starve_o = err_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: grants committed results oldest-pc-first onto registered regfile write ports,
// never writing the same rd twice in one cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  word_t            commit_pc,
    output logic [NSRC-1:0]  err_starve,
    wb_port_arbiter_if.slave bus
);
    logic [NSRC-1:0]  buf_v, grant, elig, ready, starve;
    word_t [NSRC-1:0] buf_pc, buf_data;
    rd_t [NSRC-1:0]   buf_addr;
    int               rank [NSRC];
    int               used;
    logic [31:0]      taken;
    logic [NWP-1:0]   wp_ena_d, wp_ena_q;
    rd_t [NWP-1:0]    wp_addr_d, wp_addr_q;
    word_t [NWP-1:0]  wp_data_d, wp_data_q;
    for (genvar g = 0; g < NSRC; g++) begin : g_src
        wb_port_arbiter_src_buf u_buf (
            .clk      (clk),
            .rst      (rst),
            .flush_i  (flush),
            .valid_i  (bus.req_valid[g]),
            .data_i   (bus.req_data[g]),
            .addr_i   (bus.req_addr[g]),
            .pc_i     (bus.req_pc[g]),
            .grant_i  (grant[g]),
            .ready_o  (ready[g]),
            .v_o      (buf_v[g]),
            .data_o   (buf_data[g]),
            .addr_o   (buf_addr[g]),
            .pc_o     (buf_pc[g]),
            .starve_o (starve[g])
        );
    end
    always_comb begin
        elig      = '0;
        grant     = '0;
        taken     = '0;
        used      = 0;
        wp_ena_d  = '0;
        wp_addr_d = '0;
        wp_data_d = '0;
        for (int i = 0; i < NSRC; i++)
            elig[i] = !flush && buf_v[i] && buf_pc[i] <= commit_pc;
        for (int i = 0; i < NSRC; i++) begin
            rank[i] = 0;
            for (int j = 0; j < NSRC; j++)
                if (elig[j] && older(buf_pc[j], j, buf_pc[i], i)) rank[i] = rank[i] + 1;
        end
        // rd 0 drains without a write, so it neither takes a port nor blocks a later rd 0.
        for (int p = 0; p < NSRC; p++)
            for (int i = 0; i < NSRC; i++)
                if (elig[i] && rank[i] == p && !taken[buf_addr[i]] && (buf_addr[i] == 5'd0 || used < NWP)) begin
                    grant[i] = 1'b1;
                    if (buf_addr[i] != 5'd0) begin
                        taken[buf_addr[i]] = 1'b1;
                        wp_ena_d[used]     = 1'b1;
                        wp_addr_d[used]    = buf_addr[i];
                        wp_data_d[used]    = buf_data[i];
                        used               = used + 1;
                    end
                end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_ena_q  <= '0;
            wp_addr_q <= '0;
            wp_data_q <= '0;
        end else begin
            wp_ena_q  <= wp_ena_d;
            wp_addr_q <= wp_addr_d;
            wp_data_q <= wp_data_d;
        end
    end
    assign bus.req_ready = ready;
    assign bus.wp_ena    = wp_ena_q;
    assign bus.wp_addr   = wp_addr_q;
    assign bus.wp_data   = wp_data_q;
    assign err_starve    = starve;
endmodule
